// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_pkg;
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    localparam int REGFILE_ADDR_WIDTH_DEF = 5;
    localparam int ZERO_REG               = 0;
    // Wide enough for the largest legal MEM_TIMEOUT (255).
    localparam int WAIT_CNT_WIDTH         = 8;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - datapath-side hazard inputs and stage-control outputs
interface pipe_hazard_ctrl_if
    import pipe_pkg::*;
#(
    parameter int REGFILE_ADDR_WIDTH = REGFILE_ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH          = 32
);
    logic [REGFILE_ADDR_WIDTH-1:0] id_rs_addr;
    logic [REGFILE_ADDR_WIDTH-1:0] id_rt_addr;
    logic [REGFILE_ADDR_WIDTH-1:0] ex_wr_addr;
    logic                          id_rs_used;
    logic                          id_rt_used;
    logic                          ex_is_load;
    logic                          branch_taken;
    logic                          mem_req;
    logic                          mem_ack;
    logic                          pc_en;
    logic                          if_id_en;
    logic                          id_ex_en;
    logic                          ex_mem_en;
    logic                          mem_wb_en;
    logic                          if_id_flush;
    logic                          id_ex_flush;
    logic                          mem_err;
    logic [CNT_WIDTH-1:0]          stall_cycles;

    modport master (
        output id_rs_addr, id_rt_addr, ex_wr_addr, id_rs_used, id_rt_used,
               ex_is_load, branch_taken, mem_req, mem_ack,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_err, stall_cycles
    );

    modport slave (
        input  id_rs_addr, id_rt_addr, ex_wr_addr, id_rs_used, id_rt_used,
               ex_is_load, branch_taken, mem_req, mem_ack,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_err, stall_cycles
    );
endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use comparator between ID sources and EX load destination
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int ADDR_W = REGFILE_ADDR_WIDTH_DEF
) (
    input  logic [ADDR_W-1:0] i_rs_addr,
    input  logic [ADDR_W-1:0] i_rt_addr,
    input  logic              i_rs_used,
    input  logic              i_rt_used,
    input  logic [ADDR_W-1:0] i_ex_wr_addr,
    input  logic              i_ex_is_load,
    output logic              o_load_use
);
    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = i_rs_used && (i_rs_addr == i_ex_wr_addr);
    assign w_rt_hit = i_rt_used && (i_rt_addr == i_ex_wr_addr);
    // Writes to the zero register are discarded, so they never create a dependency.
    assign o_load_use = i_ex_is_load && (i_ex_wr_addr != ADDR_W'(ZERO_REG)) && (w_rs_hit || w_rt_hit);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller for the five-stage pipeline
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REGFILE_ADDR_WIDTH = REGFILE_ADDR_WIDTH_DEF,
    parameter int MEM_TIMEOUT        = 16,
    parameter int CNT_WIDTH          = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    pipe_hazard_ctrl_if.slave bus
);
    state_t                    r_state;
    state_t                    w_next_state;
    logic [WAIT_CNT_WIDTH-1:0] r_wait_cnt;
    logic [WAIT_CNT_WIDTH-1:0] w_next_wait_cnt;
    logic                      r_mem_err;
    logic                      w_set_err;
    logic [CNT_WIDTH-1:0]      r_stall_cycles;
    logic                      w_load_use;
    logic                      w_mem_stall;
    logic                      w_pc_en;
    logic                      w_if_id_en;
    logic                      w_id_ex_en;
    logic                      w_ex_mem_en;
    logic                      w_mem_wb_en;
    logic                      w_if_id_flush;
    logic                      w_id_ex_flush;

    hazard_detect #(.ADDR_W(REGFILE_ADDR_WIDTH)) u_hazard_detect (
        .i_rs_addr    (bus.id_rs_addr),
        .i_rt_addr    (bus.id_rt_addr),
        .i_rs_used    (bus.id_rs_used),
        .i_rt_used    (bus.id_rt_used),
        .i_ex_wr_addr (bus.ex_wr_addr),
        .i_ex_is_load (bus.ex_is_load),
        .o_load_use   (w_load_use)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_RUN;
            r_wait_cnt     <= '0;
            r_mem_err      <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait_cnt;
            if (w_set_err) begin
                r_mem_err <= 1'b1;
            end
            if (!w_pc_en && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_wait_cnt = r_wait_cnt;
        w_set_err       = 1'b0;
        w_mem_stall     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.mem_req && !bus.mem_ack) begin
                    w_mem_stall     = 1'b1;
                    w_next_state    = ST_MEM_WAIT;
                    w_next_wait_cnt = WAIT_CNT_WIDTH'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (bus.mem_ack) begin
                    w_next_state    = ST_RUN;
                    w_next_wait_cnt = '0;
                end else begin
                    w_mem_stall = 1'b1;
                    if (r_wait_cnt == WAIT_CNT_WIDTH'(MEM_TIMEOUT - 1)) begin
                        w_next_state = ST_HALT;
                        w_set_err    = 1'b1;
                    end else begin
                        w_next_wait_cnt = r_wait_cnt + WAIT_CNT_WIDTH'(1);
                    end
                end
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase

        w_pc_en       = 1'b1;
        w_if_id_en    = 1'b1;
        w_id_ex_en    = 1'b1;
        w_ex_mem_en   = 1'b1;
        w_mem_wb_en   = 1'b1;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        // Reset holds every stage register in its bubble state.
        if (!reset_n) begin
            {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = '0;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end else if ((r_state == ST_HALT) || w_mem_stall) begin
            {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = '0;
        end else if (bus.branch_taken) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end else if (w_load_use) begin
            w_pc_en       = 1'b0;
            w_if_id_en    = 1'b0;
            w_id_ex_flush = 1'b1;
        end
    end

    assign bus.pc_en        = w_pc_en;
    assign bus.if_id_en     = w_if_id_en;
    assign bus.id_ex_en     = w_id_ex_en;
    assign bus.ex_mem_en    = w_ex_mem_en;
    assign bus.mem_wb_en    = w_mem_wb_en;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_flush  = w_id_ex_flush;
    assign bus.mem_err      = r_mem_err;
    assign bus.stall_cycles = r_stall_cycles;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - bench for pipe_hazard_ctrl with default and small-parameter instances
module tb_pipe_hazard_ctrl;
    logic       clk;
    logic       rstn;
    logic [4:0] rs, rt, wr;
    logic       rsu, rtu, ld, br, req, ack;

    int n_cmp = 0;
    int n_bad = 0;

    bit     m_halted [2];
    int     m_wait   [2];
    bit     m_err    [2];
    longint m_stall  [2];
    longint m_max    [2];
    int     m_tmo    [2];

    pipe_hazard_ctrl_if #(.REGFILE_ADDR_WIDTH(5), .CNT_WIDTH(32)) bus_a ();
    pipe_hazard_ctrl_if #(.REGFILE_ADDR_WIDTH(5), .CNT_WIDTH(4))  bus_b ();

    assign bus_a.id_rs_addr = rs;   assign bus_b.id_rs_addr = rs;
    assign bus_a.id_rt_addr = rt;   assign bus_b.id_rt_addr = rt;
    assign bus_a.ex_wr_addr = wr;   assign bus_b.ex_wr_addr = wr;
    assign bus_a.id_rs_used = rsu;  assign bus_b.id_rs_used = rsu;
    assign bus_a.id_rt_used = rtu;  assign bus_b.id_rt_used = rtu;
    assign bus_a.ex_is_load = ld;   assign bus_b.ex_is_load = ld;
    assign bus_a.branch_taken = br; assign bus_b.branch_taken = br;
    assign bus_a.mem_req = req;     assign bus_b.mem_req = req;
    assign bus_a.mem_ack = ack;     assign bus_b.mem_ack = ack;

    pipe_hazard_ctrl #(.REGFILE_ADDR_WIDTH(5), .MEM_TIMEOUT(16), .CNT_WIDTH(32)) dut_a (
        .clk(clk), .reset_n(rstn), .bus(bus_a));
    pipe_hazard_ctrl #(.REGFILE_ADDR_WIDTH(5), .MEM_TIMEOUT(4), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .reset_n(rstn), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}.
    function automatic logic [6:0] exp_ctl(int k);
        bit mem_hold, lu;
        if (!rstn) return 7'b0000011;
        if (m_halted[k]) return 7'b0000000;
        mem_hold = (m_wait[k] > 0) ? !ack : (req && !ack);
        if (mem_hold) return 7'b0000000;
        if (br) return 7'b1111111;
        lu = ld && (wr != 0) && ((rsu && rs == wr) || (rtu && rt == wr));
        if (lu) return 7'b0011101;
        return 7'b1111100;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_halted[k] = 0; m_wait[k] = 0; m_err[k] = 0; m_stall[k] = 0;
        end
    endtask

    task automatic model_clock();
        logic [6:0] c;
        bit mem_hold;
        if (!rstn) return;
        for (int k = 0; k < 2; k++) begin
            c = exp_ctl(k);
            if (!c[6] && m_stall[k] < m_max[k]) m_stall[k]++;
            if (!m_halted[k]) begin
                mem_hold = (m_wait[k] > 0) ? !ack : (req && !ack);
                if (mem_hold) begin
                    m_wait[k]++;
                    if (m_wait[k] >= m_tmo[k]) begin
                        m_halted[k] = 1; m_err[k] = 1; m_wait[k] = 0;
                    end
                end else begin
                    m_wait[k] = 0;
                end
            end
        end
    endtask

    function automatic logic [6:0] ctl_a();
        return {bus_a.pc_en, bus_a.if_id_en, bus_a.id_ex_en, bus_a.ex_mem_en,
                bus_a.mem_wb_en, bus_a.if_id_flush, bus_a.id_ex_flush};
    endfunction

    function automatic logic [6:0] ctl_b();
        return {bus_b.pc_en, bus_b.if_id_en, bus_b.id_ex_en, bus_b.ex_mem_en,
                bus_b.mem_wb_en, bus_b.if_id_flush, bus_b.id_ex_flush};
    endfunction

    task automatic step(input string tag);
        #1;
        chk({tag, ".ctl_a"}, 64'(ctl_a()), 64'(exp_ctl(0)));
        chk({tag, ".ctl_b"}, 64'(ctl_b()), 64'(exp_ctl(1)));
        chk({tag, ".err_a"}, 64'(bus_a.mem_err), 64'(m_err[0]));
        chk({tag, ".err_b"}, 64'(bus_b.mem_err), 64'(m_err[1]));
        chk({tag, ".stall_a"}, 64'(bus_a.stall_cycles), m_stall[0]);
        chk({tag, ".stall_b"}, 64'(bus_b.stall_cycles), m_stall[1]);
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] a_rs, input logic [4:0] a_rt, input logic a_rsu,
                          input logic a_rtu, input logic [4:0] a_wr, input logic a_ld,
                          input logic a_br, input logic a_req, input logic a_ack);
        rs = a_rs; rt = a_rt; rsu = a_rsu; rtu = a_rtu; wr = a_wr;
        ld = a_ld; br = a_br; req = a_req; ack = a_ack;
    endtask

    task automatic rand_in(input int ack_pct);
        set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
               1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 99) < 15),
               ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < ack_pct));
    endtask

    task automatic pulse_reset(input string tag);
        rstn = 1'b0;
        model_reset();
        step({tag, ".in_reset"});
        rstn = 1'b1;
    endtask

    initial begin
        m_max[0] = 64'hFFFF_FFFF; m_max[1] = 15;
        m_tmo[0] = 16;            m_tmo[1] = 4;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rstn = 1'b0;
        model_reset();
        #2;
        step("reset");
        rstn = 1'b1;
        step("idle");

        set_in(3, 0, 1, 0, 3, 1, 0, 0, 0);
        step("load_use");
        set_in(3, 0, 1, 0, 7, 0, 0, 0, 0);
        step("after_load_use");
        chk("load_use_count", 64'(bus_a.stall_cycles), 64'd1);
        set_in(0, 0, 1, 0, 0, 1, 0, 0, 0);
        step("load_zero_reg");

        set_in(3, 3, 1, 1, 3, 1, 1, 0, 0);
        step("branch_over_lu");
        chk("branch_count", 64'(bus_a.stall_cycles), 64'd1);

        set_in(1, 2, 0, 0, 4, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step("mem_wait");
        ack = 1'b1;
        step("mem_ack");
        set_in(1, 2, 0, 0, 4, 0, 0, 0, 0);
        step("mem_done");
        chk("mem_wait_count", 64'(bus_a.stall_cycles), 64'd4);

        set_in(1, 2, 0, 0, 4, 0, 0, 1, 1);
        step("req_ack_same");

        for (int i = 0; i < 200; i++) begin
            rand_in(60);
            step("rand1");
        end

        pulse_reset("pre_timeout");
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step("timeout");
        chk("halt_err_b", 64'(bus_b.mem_err), 64'd1);
        ack = 1'b1;
        step("late_ack");
        chk("halt_ctl_b", 64'(ctl_b()), 64'd0);

        req = 1'b1; ack = 1'b0;
        step("wait_for_reset");
        step("wait_for_reset");
        pulse_reset("mid_wait");
        set_in(3, 0, 1, 0, 3, 1, 0, 0, 0);
        step("post_reset_lu");

        for (int i = 0; i < 20; i++) step("saturate");
        chk("saturated_b", 64'(bus_b.stall_cycles), 64'd15);

        for (int i = 0; i < 200; i++) begin
            rand_in(80);
            step("rand2");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the five-stage integer pipeline. Each cycle it drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC enable. It resolves three hazard classes:
- load-use data hazards,
- taken-branch squashes,
- multi-cycle data-memory accesses with a req/ack handshake and a timeout.

It sits beside the datapath, one instance per core.

## Interface
Parameters:
- REGFILE_ADDR_WIDTH, 5, register-file address width.
- MEM_TIMEOUT, 16, maximum MEM_WAIT cycles before a fatal timeout (legal range 2..255).
- CNT_WIDTH, 32, stall-cycle counter width.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous, active-low reset.
- id_rs_addr, id_rt_addr  in  REGFILE_ADDR_WIDTH  source registers of the instruction in ID.
- id_rs_used, id_rt_used  in  1  the corresponding source is actually read.
- ex_wr_addr  in  REGFILE_ADDR_WIDTH  destination of the instruction in EX.
- ex_is_load  in  1  the instruction in EX is a load.
- branch_taken  in  1  branch resolved taken in EX this cycle.
- mem_req  in  1  the instruction in MEM accesses data memory.
- mem_ack  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC update enable.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  stage-register enables.
- if_id_flush, id_ex_flush  out  1  synchronous bubble insert; drives the stage register's reset input.
- mem_err  out  1  sticky memory-timeout error.
- stall_cycles  out  CNT_WIDTH  saturating count of cycles with pc_en=0.

## Operation
FSM states: RUN, MEM_WAIT, HALT. Reset state is RUN.

Enables and flushes are combinational from the state and the current inputs. Priority, highest first:

1. **HALT:** all enables 0, flushes 0, mem_err=1.
2. **Memory stall.** Condition: (RUN and mem_req=1 and mem_ack=0) or (MEM_WAIT and mem_ack=0).
   - All enables 0, flushes 0.
   - A branch_taken or load-use condition is held by the frozen stages and acted on after release.
3. **Branch taken.**
   - All enables 1.
   - if_id_flush=1 and id_ex_flush=1, which squashes the instructions in IF and ID.
   - Load-use is ignored, because the dependent instruction is squashed.
4. **Load-use.** Condition: ex_is_load=1, ex_wr_addr≠0, and (id_rs_used with id_rs_addr==ex_wr_addr, or id_rt_used with id_rt_addr==ex_wr_addr).
   - pc_en=0 and if_id_en=0.
   - id_ex_flush=1.
   - ex_mem_en=1 and mem_wb_en=1.
5. **Otherwise:** all enables 1, flushes 0.

FSM transitions:
- RUN → MEM_WAIT when mem_req=1 and mem_ack=0. The wait counter loads 1.
- mem_req=1 and mem_ack=1 in the same cycle in RUN completes the access with no stall and no state change.
- MEM_WAIT, mem_ack=1: transition to RUN. The ack cycle itself uses priorities 3–5, so the pipeline advances on that edge.
- MEM_WAIT, mem_ack=0 with wait counter == MEM_TIMEOUT-1: transition to HALT and set mem_err.
- MEM_WAIT, mem_ack=0 otherwise: the wait counter increments.
- HALT exits only on reset.

Other rules:
- mem_req and mem_ack are ignored in HALT.
- In MEM_WAIT, mem_req is not re-checked; only ack matters.
- stall_cycles increments by 1 on every cycle where pc_en=0 (HALT included). It saturates at all ones and never wraps.

## Timing
- Asynchronous reset values while reset_n=0:
  - state=RUN, wait counter=0, mem_err=0, stall_cycles=0.
  - All enables 0.
  - if_id_flush=1, id_ex_flush=1.
- After reset_n deasserts, the outputs follow normal RUN rules from the first rising edge.
- Enable/flush latency is 0 cycles (combinational). State, counters and mem_err update on the rising edge of clk.
- A load-use stall lasts exactly 1 cycle: the load moves to MEM on that edge, so the hazard condition clears.
- A memory stall of N cycles is the number of cycles with mem_ack=0 before ack. The maximum in MEM_WAIT is MEM_TIMEOUT-1 cycles before HALT.
- Reset during MEM_WAIT or HALT returns to RUN immediately and asynchronously. No pending condition is retained.

## Structure
- Shared package pipe_pkg holds:
  - the FSM state encoding (2-bit: RUN=0, MEM_WAIT=1, HALT=2),
  - the REGFILE_ADDR_WIDTH default,
  - the zero-register constant.
- One natural sub-module: hazard_detect, the purely combinational load-use comparator. The FSM, counters and priority mux stay in the top module.

## Test plan
- **Load-use.** Stimulus: ex_is_load=1, ex_wr_addr=3, id_rs_addr=3, id_rs_used=1. Required: one cycle with pc_en=0, if_id_en=0, id_ex_flush=1, mem_wb_en=1; stall_cycles=1; with ex_wr_addr=0 there is no stall.
- **Branch over load-use.** Stimulus: branch_taken=1 together with a load-use hazard. Required: all enables 1, both flushes 1, stall_cycles unchanged.
- **Memory wait.** Stimulus: mem_req=1 with mem_ack low for 3 cycles, then high. Required: all enables 0 for 3 cycles, the pipeline advances on the ack cycle, state returns to RUN, stall_cycles=3.
- **Timeout.** Stimulus: MEM_TIMEOUT=4, mem_req=1, mem_ack never asserted. Required: HALT after 4 stalled cycles, mem_err=1; a later mem_ack has no effect.
- **Reset mid-wait.** Stimulus: reset_n pulsed low during MEM_WAIT. Required: immediately all enables 0, flushes 1, mem_err=0, stall_cycles=0; normal RUN behaviour after release.
- **Saturation.** Stimulus: CNT_WIDTH=4, 20 stall cycles. Required: stall_cycles holds at 15.
